// File: rtl/pll_lock_sequencer.sv
// Power-up and lock supervisor for a PLLE2: sequences PWRDWN/RST, waits for LOCKED with bounded retries,
// and gates the downstream clock enable. Define PLL_SEQ_LOSS_COUNTER_EN to build the lock-loss counter.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwrdwn_req,
    input  logic       restart,
    input  logic       locked,
    output logic       pll_pwrdwn,
    output logic       pll_rst,
    output logic       clk_en,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PWRDN     = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 sync_q;
    logic                 locked_s_q;
    logic                 pll_pwrdwn_q, pll_pwrdwn_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 clk_en_q, clk_en_d;
    logic                 fault_q, fault_d;

    // Two-flop synchronizer for the asynchronous LOCKED pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync_q     <= locked;
            locked_s_q <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PWRDN;
            timer_q      <= '0;
            retry_cnt_q  <= '0;
            pll_pwrdwn_q <= 1'b1;
            pll_rst_q    <= 1'b1;
            clk_en_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_cnt_q  <= retry_cnt_d;
            pll_pwrdwn_q <= pll_pwrdwn_d;
            pll_rst_q    <= pll_rst_d;
            clk_en_q     <= clk_en_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they line up with the state register
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        retry_inc   = retry_cnt_q + 4'd1;

        if (pwrdwn_req) begin
            state_d = S_PWRDN;
            timer_d = '0;
        end else if (restart && (state_q != S_PWRDN)) begin
            state_d     = S_RESET;
            timer_d     = '0;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_PWRDN: begin
                    state_d = S_RESET;
                    timer_d = '0;
                end
                S_RESET: begin
                    if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_SETTLE;
                        timer_d = '0;
                    end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        retry_cnt_d = retry_inc;
                        state_d     = (retry_inc == RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_RESET;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (!locked_s_q) begin
                        retry_cnt_d = retry_inc;
                        state_d     = (retry_inc == RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_RESET;
                        timer_d     = '0;
                    end else if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) begin
                        state_d     = S_RUN;
                        retry_cnt_d = '0;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!locked_s_q) begin
                        state_d = S_RESET;
                        timer_d = '0;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_PWRDN;
                    timer_d = '0;
                end
            endcase
        end

        pll_pwrdwn_d = (state_d == S_PWRDN);
        pll_rst_d    = (state_d == S_PWRDN) || (state_d == S_RESET) || (state_d == S_FAULT);
        clk_en_d     = (state_d == S_RUN);
        fault_d      = (state_d == S_FAULT);
    end

    assign state      = state_q;
    assign pll_pwrdwn = pll_pwrdwn_q;
    assign pll_rst    = pll_rst_q;
    assign clk_en     = clk_en_q;
    assign fault      = fault_q;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;
    logic       loss_evt;

    // Counts only lock losses that actually take RUN back to RESET
    assign loss_evt = (state_q == S_RUN) && !pwrdwn_req && !restart && !locked_s_q;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and lock supervisor for a PLLE2-based clock generator. Sequences the PLL's power-down and reset pins, waits for LOCKED with a timeout and bounded retries, and requires a stable-lock settle window before asserting a downstream clock enable. In RUN it watches for lock loss and re-sequences automatically. It sits between board-level controls (switches/buttons) and the PLL primitive plus the logic fed by the PLL outputs.

## Interface
- RST_CYCLES, 16: cycles pll_rst is held high in RESET (1..65535)
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry (1..65535)
- SETTLE_CYCLES, 64: consecutive synced-lock cycles required before RUN (1..65535)
- MAX_RETRIES, 3: failed lock attempts tolerated before FAULT (1..15)

- clk  input  1  free-running reference clock (same clock that feeds the PLL input)
- rst_n  input  1  asynchronous active-low reset
- pwrdwn_req  input  1  level; request PLL power-down
- restart  input  1  single-cycle pulse; force a fresh sequence, clears retries
- locked  input  1  raw PLL LOCKED, asynchronous to clk
- pll_pwrdwn  output  1  to PLL PWRDWN
- pll_rst  output  1  to PLL RST (active-high)
- clk_en  output  1  downstream clock/logic enable
- fault  output  1  lock could not be achieved within MAX_RETRIES
- state  output  3  current state encoding
- loss_cnt  output  8  saturating count of lock losses while in RUN

## Operation
- locked passes through a 2-flop synchronizer → locked_s; the FSM uses only locked_s.
- States: PWRDN=0, RESET=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5. Outputs are Moore-decoded from the state register.
- PWRDN: pll_pwrdwn=1, pll_rst=1. Leaves to RESET on the first cycle with pwrdwn_req=0.
- RESET: pll_rst=1. After RST_CYCLES cycles → WAIT_LOCK, with the timer cleared.
- WAIT_LOCK: pll_rst=0. locked_s=1 → SETTLE. After LOCK_TIMEOUT cycles without lock: retry_cnt+1. If retry_cnt then equals MAX_RETRIES → FAULT, otherwise → RESET.
- SETTLE: after SETTLE_CYCLES consecutive cycles with locked_s=1 → RUN, and retry_cnt is cleared. If locked_s=0 first: retry_cnt+1, then → FAULT or RESET by the same rule as WAIT_LOCK.
- RUN: clk_en=1. locked_s=0 → RESET, and loss_cnt is incremented (saturates at 255).
- FAULT: pll_rst=1, fault=1. Exits only via restart or pwrdwn_req.
- Priority in every state: pwrdwn_req → PWRDN (highest), then restart → RESET with retry_cnt cleared (restart is ignored in PWRDN), then the state-local rules.
- Outputs asserted only in the listed states: pll_pwrdwn in PWRDN; pll_rst in PWRDN, RESET, FAULT; clk_en in RUN; fault in FAULT.
- loss_cnt is cleared only by rst_n.

## Timing
- Reset (rst_n=0):
  - state=PWRDN, pll_pwrdwn=1, pll_rst=1, clk_en=0, fault=0, loss_cnt=0.
  - All counters and the synchronizer are cleared.
- A raw lock change reaches locked_s 2 cycles later; the state changes on the following edge. Lock loss therefore drops clk_en on the 3rd rising edge after the falling edge of locked.
- Best case from leaving PWRDN to clk_en=1: 1 + RST_CYCLES + 3 + SETTLE_CYCLES cycles.
- pll_rst is high for exactly RST_CYCLES cycles per RESET visit.
- Simultaneous events: the timeout and locked_s=1 in the same WAIT_LOCK cycle → SETTLE (lock wins). pwrdwn_req together with restart → PWRDN.
- rst_n asserted mid-sequence returns to PWRDN immediately (asynchronously). Retries restart from 0.

## Configuration
- PLL_SEQ_LOSS_COUNTER_EN defined: the 8-bit saturating loss_cnt is implemented as described.
- PLL_SEQ_LOSS_COUNTER_EN undefined: loss_cnt is tied to 8'd0 and no counter flops are instantiated. FSM behaviour is otherwise identical.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up:
  - Stimulus: release rst_n with pwrdwn_req=0; raise locked 10 cycles after pll_rst falls.
  - Required: pll_rst high for exactly 4 cycles in RESET; clk_en rises 11 cycles after locked rises; state=4.
- Lock timeout and fault:
  - Stimulus: locked held 0.
  - Required: two RESET pulses, each followed by 32 WAIT_LOCK cycles; then state=5, fault=1, pll_rst=1.
  - Then pulse restart: fault=0 and a new 4-cycle RESET begins.
- Settle glitch:
  - Stimulus: locked rises, then drops for 1 cycle after 5 cycles high.
  - Required: no RUN entry; the FSM returns to RESET and retry_cnt=1.
  - Then hold locked stable: RUN is reached and retry_cnt is cleared.
- Lock loss in RUN:
  - Stimulus: drop locked three times while in RUN.
  - Required: clk_en falls 3 cycles after each drop; loss_cnt=3 with the macro defined, 0 without it.
- Power-down priority:
  - Stimulus: assert pwrdwn_req together with a restart pulse while in RUN.
  - Required: next state PWRDN, pll_pwrdwn=1, clk_en=0.
  - Deassert pwrdwn_req: a RESET of 4 cycles follows.
- Asynchronous reset mid-sequence:
  - Stimulus: assert rst_n during WAIT_LOCK, with no clock edge.
  - Required: outputs take their reset values immediately; loss_cnt=0.
